// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt on a simple req/ready bus.
// Optional TIMER_PRESCALE_EN adds a 16-bit tick prescaler; without it mtime ticks every enabled cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 4
`endif

module bus_timer #(
    parameter int SLAVE_ID = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [`XLEN-1:0]                bus_dat_i,
    output logic [`XLEN-1:0]                bus_dat_o,
    input  logic [`XLEN-`SLAVE_WIDTH-1:0]   bus_addr,
    input  logic [`SLAVE_WIDTH-1:0]         bus_num,
    input  logic                            bus_req,
    input  logic                            bus_wen,
    input  logic [2:0]                      bus_mode,
    output logic                            bus_ready,
    output logic                            intr
);
    localparam int AW = `XLEN - `SLAVE_WIDTH;
    localparam logic [`SLAVE_WIDTH-1:0] ID = SLAVE_ID[`SLAVE_WIDTH-1:0];

    // state | meaning
    // IDLE  | waiting for a request addressed to this slave
    // ACK   | bus_ready and read data presented for one cycle
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nx;
    logic   acc;

    logic [63:0] mtime, cmp, mtime_inc, mtime_nx;
    logic [1:0]  ctrl;
    logic        tick;
    logic [15:0] prescale_rd;

    logic [2:0]  off;
    logic [1:0]  size;
    logic        mapped, aligned, ok, wr;
    logic        wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctl;
    logic [3:0]  be;
    logic [31:0] wmask, wlane, reg_rd, lane, rd_val;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [31:0] m);
        return (old & ~m) | (nw & m);
    endfunction

    always_comb begin
        state_nx = state;
        acc      = 1'b0;
        case (state)
            IDLE: if (bus_req && bus_num == ID) begin
                state_nx = ACK;
                acc      = 1'b1;
            end
            ACK:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        off     = bus_addr[4:2];
        size    = bus_mode[1:0];
        mapped  = (bus_addr[AW-1:5] == '0) && (off <= 3'd5);
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !bus_addr[0];
            2'b10:   aligned = (bus_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        ok = mapped && aligned;

        case (size)
            2'b00:   be = 4'b0001 << bus_addr[1:0];
            2'b01:   be = bus_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) wmask[i*8 +: 8] = {8{be[i]}};
        case (size)
            2'b00:   wlane = {4{bus_dat_i[7:0]}};
            2'b01:   wlane = {2{bus_dat_i[15:0]}};
            default: wlane = bus_dat_i;
        endcase

        wr     = acc && bus_wen && ok;
        wr_mlo = wr && off == 3'd0;
        wr_mhi = wr && off == 3'd1;
        wr_clo = wr && off == 3'd2;
        wr_chi = wr && off == 3'd3;
        wr_ctl = wr && off == 3'd4;

        case (off)
            3'd0:    reg_rd = mtime[31:0];
            3'd1:    reg_rd = mtime[63:32];
            3'd2:    reg_rd = cmp[31:0];
            3'd3:    reg_rd = cmp[63:32];
            3'd4:    reg_rd = {30'd0, ctrl};
            3'd5:    reg_rd = {16'd0, prescale_rd};
            default: reg_rd = 32'd0;
        endcase
        lane = reg_rd >> {bus_addr[1:0], 3'b000};
        case (size)
            2'b00:   rd_val = {{24{!bus_mode[2] & lane[7]}}, lane[7:0]};
            2'b01:   rd_val = {{16{!bus_mode[2] & lane[15]}}, lane[15:0]};
            2'b10:   rd_val = reg_rd;
            default: rd_val = 32'd0;
        endcase
        if (!ok) rd_val = 32'd0;
    end

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale, pcnt;
    logic        wr_ps;
    assign wr_ps       = wr && off == 3'd5;
    assign tick        = ctrl[0] && (pcnt == prescale);
    assign prescale_rd = prescale;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= 16'd0;
            pcnt     <= 16'd0;
        end else begin
            if (wr_ps) begin
                prescale <= {be[1] ? wlane[15:8] : prescale[15:8],
                             be[0] ? wlane[7:0]  : prescale[7:0]};
                pcnt     <= 16'd0;
            end else if (ctrl[0]) begin
                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
            end
        end
    end
`else
    assign tick        = ctrl[0];
    assign prescale_rd = 16'd0;
`endif

    // A written half takes the bus value; the other half still sees the tick.
    always_comb begin
        mtime_inc = mtime + 64'd1;
        mtime_nx  = tick ? mtime_inc : mtime;
        if (wr_mlo) mtime_nx[31:0]  = merge(mtime[31:0], wlane, wmask);
        if (wr_mhi) mtime_nx[63:32] = merge(mtime[63:32], wlane, wmask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_ready <= 1'b0;
            bus_dat_o <= '0;
            intr      <= 1'b0;
            mtime     <= 64'd0;
            cmp       <= '1;
            ctrl      <= 2'b00;
        end else begin
            state     <= state_nx;
            bus_ready <= acc;
            bus_dat_o <= (acc && !bus_wen) ? rd_val : '0;
            mtime     <= mtime_nx;
            if (wr_clo) cmp[31:0]  <= merge(cmp[31:0], wlane, wmask);
            if (wr_chi) cmp[63:32] <= merge(cmp[63:32], wlane, wmask);
            if (wr_ctl && be[0]) ctrl <= wlane[1:0];
            intr      <= ctrl[1] && (mtime >= cmp);
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: expected read data is queued at request time and
// popped when bus_ready appears. Prescaler checks follow TIMER_PRESCALE_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 4
`endif

module tb_bus_timer;
    localparam int AW = `XLEN - `SLAVE_WIDTH;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [`XLEN-1:0]        bus_dat_i, bus_dat_o;
    logic [AW-1:0]           bus_addr;
    logic [`SLAVE_WIDTH-1:0] bus_num;
    logic                    bus_req, bus_wen;
    logic [2:0]              bus_mode;
    logic                    bus_ready, intr;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    bus_timer #(.SLAVE_ID(1)) dut (
        .clk(clk), .rst(rst), .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o),
        .bus_addr(bus_addr), .bus_num(bus_num), .bus_req(bus_req), .bus_wen(bus_wen),
        .bus_mode(bus_mode), .bus_ready(bus_ready), .intr(intr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issued from IDLE, #1 after an edge; returns once the slave is back in IDLE.
    task automatic bus_xfer(input logic wen, input logic [2:0] mode, input logic [7:0] addr,
                            input logic [31:0] wdat, input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic        seen;
        logic [31:0] exp_v;
        exp_q.push_back(wen ? 32'd0 : exp_rd);
        bus_num   = 1;
        bus_wen   = wen;
        bus_mode  = mode;
        bus_addr  = AW'(addr);
        bus_dat_i = wdat;
        bus_req   = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            seen = bus_ready;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd1);
        exp_v = exp_q.pop_front();
        if (seen) check_eq(tag, 64'(bus_dat_o), 64'(exp_v));
        bus_req = 1'b0;
        step(1);
        check_eq({tag, "_idle"}, {31'd0, bus_ready, bus_dat_o}, 64'd0);
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [2:0] mode, input logic [31:0] d,
                          input string tag);
        bus_xfer(1'b1, mode, addr, d, 32'd0, tag);
    endtask

    task automatic bus_rd(input logic [7:0] addr, input logic [2:0] mode, input logic [31:0] e,
                          input string tag);
        bus_xfer(1'b0, mode, addr, 32'd0, e, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, m, pulses;
        rst = 1'b1; bus_req = 1'b0; bus_wen = 1'b0; bus_mode = 3'b010;
        bus_addr = '0; bus_num = '0; bus_dat_i = '0;
        step(3);
        check_eq("rst_ready", 64'(bus_ready), 64'd0);
        check_eq("rst_dat", 64'(bus_dat_o), 64'd0);
        check_eq("rst_intr", 64'(intr), 64'd0);
        rst = 1'b0;
        step(1);
        bus_rd(8'h00, 3'b010, 32'd0, "rst_mtlo");
        bus_rd(8'h04, 3'b010, 32'd0, "rst_mthi");
        bus_rd(8'h08, 3'b010, 32'hFFFF_FFFF, "rst_cmplo");
        bus_rd(8'h0C, 3'b010, 32'hFFFF_FFFF, "rst_cmphi");
        bus_rd(8'h10, 3'b010, 32'd0, "rst_ctrl");
        bus_rd(8'h14, 3'b010, 32'd0, "rst_ps");

        // count rate: ticks begin on the edge after CTRL is written
        n0 = cyc;
        bus_wr(8'h10, 3'b010, 32'h3, "ctrl_en");
        step(10);
        m = cyc;
        bus_rd(8'h00, 3'b010, 32'(m - n0 - 1), "rate_a");
        step(5);
        m = cyc;
        bus_rd(8'h00, 3'b010, 32'(m - n0 - 1), "rate_b");
        bus_rd(8'h10, 3'b010, 32'h3, "ctrl_rd");

        // compare interrupt
        bus_wr(8'h10, 3'b010, 32'h0, "ctrl_off");
        bus_wr(8'h08, 3'b010, 32'd20, "cmplo_20");
        bus_wr(8'h0C, 3'b010, 32'd0, "cmphi_0");
        bus_wr(8'h00, 3'b010, 32'd0, "mtlo_0");
        bus_wr(8'h04, 3'b010, 32'd0, "mthi_0");
        n0 = cyc;
        bus_wr(8'h10, 3'b010, 32'h3, "ctrl_irq");
        while (cyc < n0 + 21) step(1);
        check_eq("intr_before", 64'(intr), 64'd0);
        step(1);
        check_eq("intr_rise", 64'(intr), 64'd1);
        bus_wr(8'h08, 3'b010, 32'hFFFF_FFFF, "cmplo_max");
        check_eq("intr_fall", 64'(intr), 64'd0);

        // carry from LO into HI, then full 64-bit wrap
        bus_wr(8'h10, 3'b010, 32'h0, "ctrl_off2");
        bus_wr(8'h00, 3'b010, 32'hFFFF_FFFF, "mtlo_max");
        bus_wr(8'h04, 3'b010, 32'd0, "mthi_0b");
        n0 = cyc;
        bus_wr(8'h10, 3'b010, 32'h1, "ctrl_cnt");
        bus_rd(8'h04, 3'b010, 32'd1, "carry_hi");
        m = cyc;
        bus_rd(8'h00, 3'b010, 32'(m - n0 - 2), "carry_lo");
        bus_wr(8'h10, 3'b010, 32'h0, "ctrl_off3");
        bus_wr(8'h00, 3'b010, 32'hFFFF_FFFF, "mtlo_max2");
        bus_wr(8'h04, 3'b010, 32'hFFFF_FFFF, "mthi_max");
        n0 = cyc;
        bus_wr(8'h10, 3'b010, 32'h1, "ctrl_cnt2");
        bus_rd(8'h04, 3'b010, 32'd0, "wrap_hi");
        m = cyc;
        bus_rd(8'h00, 3'b010, 32'(m - n0 - 2), "wrap_lo");
        bus_wr(8'h10, 3'b010, 32'h0, "ctrl_off4");

        // byte/half lanes and extension
        bus_wr(8'h08, 3'b010, 32'h1122_3344, "cmplo_word");
        bus_wr(8'h09, 3'b000, 32'h0000_0080, "cmplo_byte");
        bus_rd(8'h09, 3'b000, 32'hFFFF_FF80, "byte_sx");
        bus_rd(8'h09, 3'b100, 32'h0000_0080, "byte_zx");
        bus_rd(8'h08, 3'b010, 32'h1122_8044, "byte_word");
        bus_wr(8'h0A, 3'b001, 32'h0000_BEEF, "cmplo_half");
        bus_rd(8'h0A, 3'b001, 32'hFFFF_BEEF, "half_sx");
        bus_rd(8'h0A, 3'b101, 32'h0000_BEEF, "half_zx");
        bus_rd(8'h0B, 3'b100, 32'h0000_00BE, "byte3_zx");

        // misaligned and unmapped
        bus_rd(8'h06, 3'b010, 32'd0, "misal_word");
        bus_rd(8'h09, 3'b001, 32'd0, "misal_half");
        bus_rd(8'h1C, 3'b010, 32'd0, "unmapped");
        bus_wr(8'h0A, 3'b010, 32'h0, "misal_wr");
        bus_rd(8'h08, 3'b010, 32'hBEEF_8044, "misal_kept");

        // back-to-back with req held high
        bus_num = 1; bus_wen = 1'b0; bus_mode = 3'b010; bus_addr = AW'(8'h10); bus_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus_ready) pulses++;
        end
        check_eq("b2b_pulses", 64'(pulses), 64'd2);
        bus_req = 1'b0;
        step(1);

        // other slave selected
        bus_num = 2; bus_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus_ready) pulses++;
        end
        check_eq("other_num", 64'(pulses), 64'd0);
        bus_req = 1'b0;
        step(1);

`ifdef TIMER_PRESCALE_EN
        bus_wr(8'h14, 3'b010, 32'h0001_0003, "ps_wr");
        bus_rd(8'h14, 3'b010, 32'h3, "ps_rd");
        bus_wr(8'h00, 3'b010, 32'd0, "mtlo_0c");
        bus_wr(8'h04, 3'b010, 32'd0, "mthi_0c");
        n0 = cyc;
        bus_wr(8'h10, 3'b010, 32'h1, "ctrl_ps");
        step(7);
        m = cyc;
        bus_rd(8'h00, 3'b010, 32'((m - n0 - 1) / 4), "ps_cnt_a");
        step(9);
        m = cyc;
        bus_rd(8'h00, 3'b010, 32'((m - n0 - 1) / 4), "ps_cnt_b");
`else
        bus_wr(8'h14, 3'b010, 32'h3, "ps_wr");
        bus_rd(8'h14, 3'b010, 32'd0, "ps_rd");
`endif

        // reset landing on the accept edge
        bus_wr(8'h10, 3'b010, 32'h3, "ctrl_pre_rst");
        bus_num = 1; bus_wen = 1'b1; bus_mode = 3'b010; bus_addr = AW'(8'h08);
        bus_dat_i = 32'h55; bus_req = 1'b1; rst = 1'b1;
        step(1);
        check_eq("rst_acc_ready", 64'(bus_ready), 64'd0);
        bus_req = 1'b0; rst = 1'b0;
        step(1);
        check_eq("rst_acc_ready2", 64'(bus_ready), 64'd0);
        check_eq("rst_acc_intr", 64'(intr), 64'd0);
        bus_rd(8'h08, 3'b010, 32'hFFFF_FFFF, "rst_acc_cmp");
        bus_rd(8'h10, 3'b010, 32'd0, "rst_acc_ctrl");
        bus_rd(8'h00, 3'b010, 32'd0, "rst_acc_mtlo");
        bus_rd(8'h14, 3'b010, 32'd0, "rst_acc_ps");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 1, the bus_num value this responder answers to.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port bus_dat_i  input  `XLEN  write data from the initiator.
REQ-005 SHALL have port bus_dat_o  output  `XLEN  read data to the initiator.
REQ-006 SHALL have port bus_addr  input  `XLEN-`SLAVE_WIDTH  byte offset within the slave.
REQ-007 SHALL have port bus_num  input  `SLAVE_WIDTH  slave select.
REQ-008 SHALL have port bus_req  input  1  request valid; initiator holds addr/num/wen/mode/dat stable until bus_ready.
REQ-009 SHALL have port bus_wen  input  1  1 = write, 0 = read.
REQ-010 SHALL have port bus_mode  input  3  access mode: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; writes use bus_mode[1:0] as size only.
REQ-011 SHALL have port bus_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port intr  output  1  level timer interrupt to the core.

Function
REQ-013 SHALL decode offsets (bus_addr[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL (bit0 count enable, bit1 irq enable, others read 0), 5 PRESCALE (bits 15:0); offsets >5 or bus_addr above 0x17 are unmapped.
REQ-014 SHALL implement FSM IDLE/ACK: IDLE -> ACK when bus_req=1 and bus_num=SLAVE_ID; ACK -> IDLE unconditionally.
REQ-015 SHALL perform writes on the IDLE->ACK edge and drive bus_ready=1 with bus_dat_o valid only in ACK, giving 2 cycles per access.
REQ-016 SHALL treat bus_req still high in the cycle after ACK as a new request (back-to-back accesses every 2 cycles).
REQ-017 SHALL hold bus_ready=0 and bus_dat_o=0 in IDLE and never respond when bus_num!=SLAVE_ID.
REQ-018 SHALL update only the addressed byte lanes on byte (addr[1:0]) and half (addr[1]) writes.
REQ-019 SHALL return reads right-aligned from the addressed lane, sign- or zero-extended per bus_mode.
REQ-020 SHALL, on misaligned half/word or unmapped accesses, still pulse bus_ready, return 0 on reads and ignore writes.
REQ-021 SHALL increment 64-bit mtime by 1 on each tick while CTRL[0]=1, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-022 SHALL give a bus write to MTIME_LO/HI priority over the tick in the same cycle; carry from a tick SHALL not propagate into a half being written.
REQ-023 SHALL register intr = CTRL[1] and (mtime >= cmp, unsigned 64-bit), updating one cycle after its inputs change.
REQ-024 SHALL leave mtime, cmp and prescale counter unchanged while CTRL[0]=0.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set FSM=IDLE, bus_ready=0, bus_dat_o=0, intr=0, mtime=0, cmp=all ones, CTRL=0, PRESCALE=0, prescale counter=0.
REQ-026 SHALL abandon an in-flight access on reset without asserting bus_ready; the write, if sampled before reset, is discarded by reset values.

Configuration
REQ-027 SHALL, with TIMER_PRESCALE_EN defined, tick when the 16-bit prescale counter equals PRESCALE, then clear it (PRESCALE=0 -> tick every cycle; PRESCALE=N -> every N+1 cycles); a PRESCALE write clears the counter.
REQ-028 SHALL, without TIMER_PRESCALE_EN, tick every cycle, read PRESCALE as 0 and ignore its writes.

Verification
REQ-029 SHALL cover: write word 0x0000_0003 to CTRL (num=SLAVE_ID) -> bus_ready high exactly 2nd cycle after req; read MTIME_LO 10 cycles later -> value increments by 1/cycle.
REQ-030 SHALL cover: write CMP_LO=20, CMP_HI=0, MTIME=0, CTRL=3 -> intr rises one cycle after mtime reaches 20; write CMP_LO=0xFFFF_FFFF -> intr falls.
REQ-031 SHALL cover: MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, enable -> next tick reads HI=1, LO=0; full 64-bit all-ones wraps to 0.
REQ-032 SHALL cover: byte write 0x80 to CMP_LO addr 0x09, read mode 000 -> 0xFFFF_FF80, mode 100 -> 0x0000_0080, other bytes unchanged.
REQ-033 SHALL cover: word read at addr 0x06 and read of offset 0x1C -> bus_ready pulses, data 0; request with bus_num!=SLAVE_ID -> no bus_ready for 10 cycles.
REQ-034 SHALL cover: with TIMER_PRESCALE_EN, PRESCALE=3 -> mtime +1 every 4 cycles; rst asserted during ACK-pending IDLE->ACK edge -> bus_ready stays 0, all registers at reset values.
